midori_share_codec: RTL and testbench

- Boundary block for the 3-share Midori64 threshold datapath.
- Encoder side: splits each unmasked 64-bit plaintext into three Boolean shares using 128 bits of fresh randomness, then hands them to the round datapath.
- Decoder side: accepts the three 64-bit output shares from the datapath and recombines them into the ciphertext through a two-stage registered XOR.
- Also tracks blocks in flight and raises sticky flags on randomness misuse and protocol underflow.

---
 rtl/midori_share_codec_if.sv | 42 ++++
 rtl/midori_share_codec.sv | 145 ++++++++++++++
 tb/tb_midori_share_codec.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midori_share_codec_if.sv
// Handshake bundle between the 3-share Midori64 boundary codec and its neighbours:
// plaintext/PRNG producers, the masked round datapath and the ciphertext consumer.
interface midori_share_codec_if #(
  parameter int CNT_W = 3
);
  logic [63:0]      pt_in;
  logic             pt_valid;
  logic             pt_ready;
  logic [127:0]     rnd_in;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [63:0]      sh_out_1;
  logic [63:0]      sh_out_2;
  logic [63:0]      sh_out_3;
  logic             sh_out_valid;
  logic             sh_out_ready;
  logic [63:0]      sh_in_1;
  logic [63:0]      sh_in_2;
  logic [63:0]      sh_in_3;
  logic             sh_in_valid;
  logic             sh_in_ready;
  logic [63:0]      ct_out;
  logic             ct_valid;
  logic             ct_ready;
  logic [CNT_W-1:0] inflight;
  logic             err_rnd_reuse;
  logic             err_underflow;

  modport slave (
    input  pt_in, pt_valid, rnd_in, rnd_valid, sh_out_ready,
           sh_in_1, sh_in_2, sh_in_3, sh_in_valid, ct_ready,
    output pt_ready, rnd_ready, sh_out_1, sh_out_2, sh_out_3, sh_out_valid,
           sh_in_ready, ct_out, ct_valid, inflight, err_rnd_reuse, err_underflow
  );

  modport master (
    output pt_in, pt_valid, rnd_in, rnd_valid, sh_out_ready,
           sh_in_1, sh_in_2, sh_in_3, sh_in_valid, ct_ready,
    input  pt_ready, rnd_ready, sh_out_1, sh_out_2, sh_out_3, sh_out_valid,
           sh_in_ready, ct_out, ct_valid, inflight, err_rnd_reuse, err_underflow
  );
endinterface

// File: rtl/midori_share_codec.sv
// Boundary codec for the 3-share Midori64 datapath: Boolean-masks plaintexts on the way in,
// recombines result shares into ciphertext on the way out, and polices in-flight/PRNG misuse.
module midori_share_codec #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input logic                 clk,
  input logic                 rst,
  midori_share_codec_if.slave bus
);

  logic             encOk;
  logic             encFire;
  logic             shInReady;
  logic             decAccept;
  logic             advanceB;

  logic [63:0]      shOut1_q, shOut1_d;
  logic [63:0]      shOut2_q, shOut2_d;
  logic [63:0]      shOut3_q, shOut3_d;
  logic             shOutValid_q, shOutValid_d;
  logic [127:0]     lastRnd_q, lastRnd_d;
  logic             firstDone_q, firstDone_d;
  logic             errRnd_q, errRnd_d;
  logic             errUnd_q, errUnd_d;
  logic [63:0]      tA_q, tA_d;
  logic [63:0]      s3A_q, s3A_d;
  logic             vA_q, vA_d;
  logic [63:0]      ctOut_q, ctOut_d;
  logic             vB_q, vB_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  // Plaintext and randomness are only ever consumed together, so both readies share encOk.
  always_comb begin
    encOk     = (!shOutValid_q || bus.sh_out_ready) &&
                (inflight_q < CNT_W'(MAX_INFLIGHT));
    encFire   = bus.pt_valid && bus.rnd_valid && encOk;
    shInReady = !vA_q || !vB_q || bus.ct_ready;
    decAccept = bus.sh_in_valid && shInReady;
    advanceB  = vA_q && (!vB_q || bus.ct_ready);
  end

  always_comb begin
    shOut1_d     = shOut1_q;
    shOut2_d     = shOut2_q;
    shOut3_d     = shOut3_q;
    shOutValid_d = shOutValid_q;
    lastRnd_d    = lastRnd_q;
    firstDone_d  = firstDone_q;
    errRnd_d     = errRnd_q;
    errUnd_d     = errUnd_q;
    tA_d         = tA_q;
    s3A_d        = s3A_q;
    vA_d         = vA_q;
    ctOut_d      = ctOut_q;
    vB_d         = vB_q;
    inflight_d   = inflight_q;

    if (encFire) begin
      shOut1_d     = bus.rnd_in[63:0];
      shOut2_d     = bus.rnd_in[127:64];
      shOut3_d     = bus.pt_in ^ bus.rnd_in[63:0] ^ bus.rnd_in[127:64];
      shOutValid_d = 1'b1;
      if ((bus.rnd_in == '0) || (firstDone_q && (bus.rnd_in == lastRnd_q)))
        errRnd_d = 1'b1;
      lastRnd_d   = bus.rnd_in;
      firstDone_d = 1'b1;
    end else if (bus.sh_out_ready) begin
      shOutValid_d = 1'b0;
    end

    // Recombination is split over two registers so no single cone sees all three shares.
    if (decAccept) begin
      tA_d  = bus.sh_in_1 ^ bus.sh_in_2;
      s3A_d = bus.sh_in_3;
      vA_d  = 1'b1;
    end else if (advanceB) begin
      vA_d = 1'b0;
    end

    if (advanceB) begin
      ctOut_d = tA_q ^ s3A_q;
      vB_d    = 1'b1;
    end else if (bus.ct_ready) begin
      vB_d = 1'b0;
    end

    if (encFire && !decAccept) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!encFire && decAccept) begin
      if (inflight_q == '0)
        errUnd_d = 1'b1;
      else
        inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shOut1_q     <= '0;
      shOut2_q     <= '0;
      shOut3_q     <= '0;
      shOutValid_q <= 1'b0;
      lastRnd_q    <= '0;
      firstDone_q  <= 1'b0;
      errRnd_q     <= 1'b0;
      errUnd_q     <= 1'b0;
      tA_q         <= '0;
      s3A_q        <= '0;
      vA_q         <= 1'b0;
      ctOut_q      <= '0;
      vB_q         <= 1'b0;
      inflight_q   <= '0;
    end else begin
      shOut1_q     <= shOut1_d;
      shOut2_q     <= shOut2_d;
      shOut3_q     <= shOut3_d;
      shOutValid_q <= shOutValid_d;
      lastRnd_q    <= lastRnd_d;
      firstDone_q  <= firstDone_d;
      errRnd_q     <= errRnd_d;
      errUnd_q     <= errUnd_d;
      tA_q         <= tA_d;
      s3A_q        <= s3A_d;
      vA_q         <= vA_d;
      ctOut_q      <= ctOut_d;
      vB_q         <= vB_d;
      inflight_q   <= inflight_d;
    end
  end

  assign bus.pt_ready      = encOk && bus.rnd_valid;
  assign bus.rnd_ready     = encOk && bus.pt_valid;
  assign bus.sh_out_1      = shOut1_q;
  assign bus.sh_out_2      = shOut2_q;
  assign bus.sh_out_3      = shOut3_q;
  assign bus.sh_out_valid  = shOutValid_q;
  assign bus.sh_in_ready   = shInReady;
  assign bus.ct_out        = ctOut_q;
  assign bus.ct_valid      = vB_q;
  assign bus.inflight      = inflight_q;
  assign bus.err_rnd_reuse = errRnd_q;
  assign bus.err_underflow = errUnd_q;

endmodule

// File: tb/tb_midori_share_codec.sv
// Self-checking bench for midori_share_codec: directed scenarios plus a randomized run
// compared against a transaction-level model (slot occupancy, counters, pending-result queue).
module tb_midori_share_codec;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0]  vecPt;
  logic [127:0] vecRnd;
  logic [63:0]  vecS1, vecS2, vecS3;

  midori_share_codec_if #(.CNT_W(3)) bus ();

  midori_share_codec #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyIdle();
    bus.pt_in        = '0;
    bus.pt_valid     = 1'b0;
    bus.rnd_in       = '0;
    bus.rnd_valid    = 1'b0;
    bus.sh_out_ready = 1'b0;
    bus.sh_in_1      = '0;
    bus.sh_in_2      = '0;
    bus.sh_in_3      = '0;
    bus.sh_in_valid  = 1'b0;
    bus.ct_ready     = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    applyIdle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (bus.sh_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_sh_out_valid: got %b want 0", bus.sh_out_valid); end
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_ct_valid: got %b want 0", bus.ct_valid); end
    checks++; if (bus.inflight !== 3'd0) begin errors++; $display("[TB] FAIL rst_inflight: got %0d want 0", bus.inflight); end
    checks++; if (bus.err_rnd_reuse !== 1'b0 || bus.err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b%b want 00", bus.err_rnd_reuse, bus.err_underflow); end
    checks++; if (bus.ct_out !== 64'd0 || bus.sh_out_3 !== 64'd0) begin errors++; $display("[TB] FAIL rst_data: got ct=%h sh3=%h want 0", bus.ct_out, bus.sh_out_3); end
  endtask

  task automatic test_encode_vector();
    applyReset();
    vecPt  = 64'h0123456789ABCDEF;
    vecRnd = {64'hFFFF0000FFFF0000, 64'h00000000DEADBEEF};
    bus.pt_in = vecPt; bus.rnd_in = vecRnd;
    bus.pt_valid = 1'b1; bus.rnd_valid = 1'b1;
    bus.sh_out_ready = 1'b1; bus.ct_ready = 1'b1;
    #1;
    checks++; if (bus.pt_ready !== 1'b1 || bus.rnd_ready !== 1'b1) begin errors++; $display("[TB] FAIL vec_ready: got %b%b want 11", bus.pt_ready, bus.rnd_ready); end
    @(negedge clk);
    bus.pt_valid = 1'b0; bus.rnd_valid = 1'b0;
    vecS1 = bus.sh_out_1; vecS2 = bus.sh_out_2; vecS3 = bus.sh_out_3;
    checks++; if (bus.sh_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL vec_sh_valid: got %b want 1", bus.sh_out_valid); end
    checks++; if (bus.sh_out_1 !== 64'h00000000DEADBEEF) begin errors++; $display("[TB] FAIL vec_sh1: got %h want 00000000deadbeef", bus.sh_out_1); end
    checks++; if (bus.sh_out_2 !== 64'hFFFF0000FFFF0000) begin errors++; $display("[TB] FAIL vec_sh2: got %h want ffff0000ffff0000", bus.sh_out_2); end
    checks++; if (bus.sh_out_3 !== 64'hFEDC4567A8F97300) begin errors++; $display("[TB] FAIL vec_sh3: got %h want fedc4567a8f97300", bus.sh_out_3); end
    checks++; if ((bus.sh_out_1 ^ bus.sh_out_2 ^ bus.sh_out_3) !== vecPt) begin errors++; $display("[TB] FAIL vec_share_xor: got %h want %h", bus.sh_out_1 ^ bus.sh_out_2 ^ bus.sh_out_3, vecPt); end
    checks++; if (bus.inflight !== 3'd1) begin errors++; $display("[TB] FAIL vec_inflight: got %0d want 1", bus.inflight); end
  endtask

  task automatic test_decode_vector();
    bus.sh_in_1 = vecS1; bus.sh_in_2 = vecS2; bus.sh_in_3 = vecS3;
    bus.sh_in_valid = 1'b1;
    #1;
    checks++; if (bus.sh_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dec_ready: got %b want 1", bus.sh_in_ready); end
    @(negedge clk);
    bus.sh_in_valid = 1'b0;
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec_latency1: got ct_valid %b want 0", bus.ct_valid); end
    checks++; if (bus.inflight !== 3'd0) begin errors++; $display("[TB] FAIL dec_inflight: got %0d want 0", bus.inflight); end
    checks++; if (bus.sh_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec_sh_clear: got %b want 0", bus.sh_out_valid); end
    @(negedge clk);
    checks++; if (bus.ct_valid !== 1'b1 || bus.ct_out !== vecPt) begin errors++; $display("[TB] FAIL dec_ct: got v=%b %h want v=1 %h", bus.ct_valid, bus.ct_out, vecPt); end
    @(negedge clk);
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec_ct_clear: got %b want 0", bus.ct_valid); end
  endtask

  task automatic test_inflight_limit();
    int accepted;
    applyReset();
    bus.sh_out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      bus.pt_in = {$urandom, $urandom};
      bus.rnd_in = {32'(i + 1), $urandom, $urandom, $urandom};
      bus.pt_valid = 1'b1; bus.rnd_valid = 1'b1;
      #1;
      if (bus.pt_ready) accepted++;
      @(negedge clk);
    end
    checks++; if (accepted != 1) begin errors++; $display("[TB] FAIL blocked_accepts: got %0d want 1", accepted); end
    checks++; if (bus.inflight !== 3'd1) begin errors++; $display("[TB] FAIL blocked_inflight: got %0d want 1", bus.inflight); end
    bus.sh_out_ready = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.pt_in = {$urandom, $urandom};
      bus.rnd_in = {32'(i + 16), $urandom, $urandom, $urandom};
      #1;
      if (bus.pt_ready) accepted++;
      @(negedge clk);
    end
    checks++; if (accepted != 3) begin errors++; $display("[TB] FAIL release_accepts: got %0d want 3", accepted); end
    checks++; if (bus.inflight !== 3'd4) begin errors++; $display("[TB] FAIL full_inflight: got %0d want 4", bus.inflight); end
    bus.sh_in_1 = {$urandom, $urandom}; bus.sh_in_2 = {$urandom, $urandom}; bus.sh_in_3 = {$urandom, $urandom};
    bus.sh_in_valid = 1'b1; bus.ct_ready = 1'b1;
    #1;
    checks++; if (bus.pt_ready !== 1'b0 || bus.rnd_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b%b want 00", bus.pt_ready, bus.rnd_ready); end
    @(negedge clk);
    bus.sh_in_valid = 1'b0;
    checks++; if (bus.inflight !== 3'd3) begin errors++; $display("[TB] FAIL drain_inflight: got %0d want 3", bus.inflight); end
    #1;
    checks++; if (bus.pt_ready !== 1'b1) begin errors++; $display("[TB] FAIL reopen_ready: got %b want 1", bus.pt_ready); end
    bus.pt_valid = 1'b0; bus.rnd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rnd_reuse();
    logic [127:0] r;
    applyReset();
    r = {32'hA5A50001, $urandom, $urandom, $urandom};
    bus.pt_in = {$urandom, $urandom}; bus.rnd_in = r;
    bus.pt_valid = 1'b1; bus.rnd_valid = 1'b1; bus.sh_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.err_rnd_reuse !== 1'b0) begin errors++; $display("[TB] FAIL reuse_first: got %b want 0", bus.err_rnd_reuse); end
    @(negedge clk);
    bus.pt_valid = 1'b0; bus.rnd_valid = 1'b0;
    checks++; if (bus.err_rnd_reuse !== 1'b1) begin errors++; $display("[TB] FAIL reuse_repeat: got %b want 1", bus.err_rnd_reuse); end
    checks++; if (bus.inflight !== 3'd2) begin errors++; $display("[TB] FAIL reuse_continues: got %0d want 2", bus.inflight); end
    applyReset();
    bus.pt_in = {$urandom, $urandom}; bus.rnd_in = '0;
    bus.pt_valid = 1'b1; bus.rnd_valid = 1'b1; bus.sh_out_ready = 1'b1;
    @(negedge clk);
    bus.pt_valid = 1'b0; bus.rnd_valid = 1'b0;
    checks++; if (bus.err_rnd_reuse !== 1'b1) begin errors++; $display("[TB] FAIL reuse_zero: got %b want 1", bus.err_rnd_reuse); end
  endtask

  task automatic test_underflow_and_simultaneous();
    logic [63:0] a, b, c;
    applyReset();
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    bus.sh_in_1 = a; bus.sh_in_2 = b; bus.sh_in_3 = c;
    bus.sh_in_valid = 1'b1; bus.ct_ready = 1'b1;
    @(negedge clk);
    bus.sh_in_valid = 1'b0;
    checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_flag: got %b want 1", bus.err_underflow); end
    checks++; if (bus.inflight !== 3'd0) begin errors++; $display("[TB] FAIL underflow_count: got %0d want 0", bus.inflight); end
    @(negedge clk);
    checks++; if (bus.ct_valid !== 1'b1 || bus.ct_out !== (a ^ b ^ c)) begin errors++; $display("[TB] FAIL underflow_ct: got v=%b %h want v=1 %h", bus.ct_valid, bus.ct_out, a ^ b ^ c); end
    bus.sh_out_ready = 1'b1; bus.pt_valid = 1'b1; bus.rnd_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.pt_in = {$urandom, $urandom};
      bus.rnd_in = {32'(i + 100), $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    checks++; if (bus.inflight !== 3'd2) begin errors++; $display("[TB] FAIL simul_pre: got %0d want 2", bus.inflight); end
    bus.rnd_in = {32'h0000_0200, $urandom, $urandom, $urandom};
    bus.sh_in_valid = 1'b1;
    #1;
    checks++; if (bus.pt_ready !== 1'b1 || bus.sh_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL simul_ready: got %b%b want 11", bus.pt_ready, bus.sh_in_ready); end
    @(negedge clk);
    applyIdle();
    checks++; if (bus.inflight !== 3'd2) begin errors++; $display("[TB] FAIL simul_count: got %0d want 2", bus.inflight); end
  endtask

  task automatic test_reset_midflight();
    applyReset();
    bus.pt_in = {$urandom, $urandom}; bus.rnd_in = {32'h0000_0301, $urandom, $urandom, $urandom};
    bus.pt_valid = 1'b1; bus.rnd_valid = 1'b1;
    bus.sh_in_1 = {$urandom, $urandom}; bus.sh_in_2 = {$urandom, $urandom}; bus.sh_in_3 = {$urandom, $urandom};
    bus.sh_in_valid = 1'b1;
    @(negedge clk);
    bus.sh_in_1 = {$urandom, $urandom};
    @(negedge clk);
    applyIdle();
    checks++; if (bus.sh_out_valid !== 1'b1 || bus.ct_valid !== 1'b1 || bus.sh_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_fill: got shv=%b ctv=%b rdy=%b want 1 1 0", bus.sh_out_valid, bus.ct_valid, bus.sh_in_ready); end
    checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL mid_underflow: got %b want 1", bus.err_underflow); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.sh_out_valid !== 1'b0 || bus.ct_valid !== 1'b0 || bus.sh_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_valids: got shv=%b ctv=%b rdy=%b want 0 0 1", bus.sh_out_valid, bus.ct_valid, bus.sh_in_ready); end
    checks++; if (bus.inflight !== 3'd0 || bus.err_underflow !== 1'b0 || bus.err_rnd_reuse !== 1'b0) begin errors++; $display("[TB] FAIL async_state: got cnt=%0d flags=%b%b want 0 00", bus.inflight, bus.err_rnd_reuse, bus.err_underflow); end
    @(negedge clk);
    rst = 1'b0;
    bus.ct_ready = 1'b1; bus.sh_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.ct_valid !== 1'b0 || bus.sh_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_after_reset: got ctv=%b shv=%b want 0 0", bus.ct_valid, bus.sh_out_valid); end
    end
  endtask

  task automatic test_random();
    bit           slotFull, firstDone, expErrRnd, expErrUnd;
    bit           expPtReady, encFire, decAcc, ctHand;
    logic [63:0]  slotPt;
    logic [127:0] slotRnd, lastRnd, r;
    int           count;
    logic [63:0]  pend[$];
    applyReset();
    slotFull = 0; firstDone = 0; expErrRnd = 0; expErrUnd = 0;
    slotPt = '0; slotRnd = '0; lastRnd = '0; count = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (bus.sh_out_valid !== slotFull) begin errors++; $display("[TB] FAIL rnd_sh_valid @%0d: got %b want %b", cyc, bus.sh_out_valid, slotFull); end
      if (slotFull) begin
        checks++; if (bus.sh_out_1 !== slotRnd[63:0] || bus.sh_out_2 !== slotRnd[127:64] || (bus.sh_out_1 ^ bus.sh_out_2 ^ bus.sh_out_3) !== slotPt) begin errors++; $display("[TB] FAIL rnd_shares @%0d: got %h %h %h want rnd %h pt %h", cyc, bus.sh_out_1, bus.sh_out_2, bus.sh_out_3, slotRnd, slotPt); end
      end
      checks++; if (bus.inflight !== 3'(count)) begin errors++; $display("[TB] FAIL rnd_inflight @%0d: got %0d want %0d", cyc, bus.inflight, count); end
      checks++; if (bus.err_rnd_reuse !== expErrRnd || bus.err_underflow !== expErrUnd) begin errors++; $display("[TB] FAIL rnd_flags @%0d: got %b%b want %b%b", cyc, bus.err_rnd_reuse, bus.err_underflow, expErrRnd, expErrUnd); end
      checks++; if (pend.size() > 2) begin errors++; $display("[TB] FAIL rnd_dec_latency @%0d: got %0d pending want <=2", cyc, pend.size()); end
      if (bus.ct_valid) begin
        checks++;
        if (pend.size() == 0) begin errors++; $display("[TB] FAIL rnd_ct_spurious @%0d: got ct %h want none", cyc, bus.ct_out); end
        else if (bus.ct_out !== pend[0]) begin errors++; $display("[TB] FAIL rnd_ct @%0d: got %h want %h", cyc, bus.ct_out, pend[0]); end
      end

      bus.pt_in = {$urandom, $urandom};
      bus.pt_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 31))
        0:       r = '0;
        1, 2:    r = lastRnd;
        default: r = {$urandom, $urandom, $urandom, $urandom};
      endcase
      bus.rnd_in = r;
      bus.rnd_valid = ($urandom_range(0, 3) != 0);
      bus.sh_out_ready = ($urandom_range(0, 2) != 0);
      bus.sh_in_1 = {$urandom, $urandom}; bus.sh_in_2 = {$urandom, $urandom}; bus.sh_in_3 = {$urandom, $urandom};
      bus.sh_in_valid = (count > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      bus.ct_ready = ($urandom_range(0, 3) != 0);
      #1;

      expPtReady = (!slotFull || bus.sh_out_ready) && (count < 4);
      checks++; if (bus.pt_ready !== (expPtReady && bus.rnd_valid) || bus.rnd_ready !== (expPtReady && bus.pt_valid)) begin errors++; $display("[TB] FAIL rnd_enc_ready @%0d: got %b%b want %b%b", cyc, bus.pt_ready, bus.rnd_ready, expPtReady && bus.rnd_valid, expPtReady && bus.pt_valid); end
      if (pend.size() < 2) begin
        checks++; if (bus.sh_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rnd_dec_ready @%0d: got %b want 1", cyc, bus.sh_in_ready); end
      end

      encFire = bus.pt_valid && bus.rnd_valid && expPtReady;
      decAcc  = bus.sh_in_valid && bus.sh_in_ready;
      ctHand  = bus.ct_valid && bus.ct_ready;
      if (encFire) begin
        if (r == '0 || (firstDone && r == lastRnd)) expErrRnd = 1;
        lastRnd = r; firstDone = 1;
        slotFull = 1; slotPt = bus.pt_in; slotRnd = r;
      end else if (bus.sh_out_ready) begin
        slotFull = 0;
      end
      if (encFire && !decAcc) count++;
      else if (decAcc && !encFire) begin
        if (count == 0) expErrUnd = 1;
        else count--;
      end
      if (ctHand && pend.size() > 0) void'(pend.pop_front());
      if (decAcc) pend.push_back(bus.sh_in_1 ^ bus.sh_in_2 ^ bus.sh_in_3);
      @(negedge clk);
    end

    applyIdle();
    bus.ct_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.ct_valid) begin
        checks++;
        if (pend.size() == 0) begin errors++; $display("[TB] FAIL drain_ct_spurious: got ct %h want none", bus.ct_out); end
        else begin
          if (bus.ct_out !== pend[0]) begin errors++; $display("[TB] FAIL drain_ct: got %h want %h", bus.ct_out, pend[0]); end
          void'(pend.pop_front());
        end
      end
      @(negedge clk);
    end
    checks++; if (pend.size() != 0) begin errors++; $display("[TB] FAIL drain_pending: got %0d left want 0", pend.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyIdle();
    test_reset();
    test_encode_vector();
    test_decode_vector();
    test_inflight_limit();
    test_rnd_reuse();
    test_underflow_and_simultaneous();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
